neopix_frame_arbiter: RTL and testbench

NEOPIX_FRAME_ARBITER -- requirements
Module: neopix_frame_arbiter

---
 rtl/neopix_frame_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_neopix_frame_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopix_frame_arbiter.sv
// -----------------------------------------------------------------------------
// neopix_frame_arbiter
//
// Shares one NeoPixel bit serializer between NUM_CH frame buffers. A requesting
// channel is granted round-robin, its frame is read pixel by pixel from its
// buffer and handed to the serializer, and after the last pixel has been
// shifted out the line is held idle-low for LATCH_CLKS cycles so the LED
// strip latches. The grant stays up through that gap because GNT also routes
// the serializer output to the granted channel's DO pin.
//
// Ports
//   CLK        system clock, single domain
//   RESET      asynchronous active-high reset
//   REQ        per-channel "frame ready" level requests
//   GNT        one-hot grant / DO routing select
//   SEL        binary index of the granted channel
//   RD_EN      frame-buffer read strobe (one cycle per pixel)
//   ADDR       pixel index being read
//   RD_DATA    pixel word from the buffer, valid one cycle after RD_EN
//   PIX_DATA   pixel word presented to the serializer
//   PIX_VALID  PIX_DATA valid
//   PIX_READY  serializer accepts the word when PIX_VALID && PIX_READY
//   SER_BUSY   serializer still shifting bits
//   DONE       one-cycle pulse on the finished channel's bit
//   BUSY       high in every state except IDLE
// -----------------------------------------------------------------------------
module neopix_frame_arbiter #(
    parameter int NUM_LEDS   = 256,
    parameter int NUM_CH     = 2,
    parameter int LATCH_CLKS = 2600
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_CH-1:0]           REQ,
    output logic [NUM_CH-1:0]           GNT,
    output logic [$clog2(NUM_CH)-1:0]   SEL,
    output logic                        RD_EN,
    output logic [$clog2(NUM_LEDS)-1:0] ADDR,
    input  logic [23:0]                 RD_DATA,
    output logic [23:0]                 PIX_DATA,
    output logic                        PIX_VALID,
    input  logic                        PIX_READY,
    input  logic                        SER_BUSY,
    output logic [NUM_CH-1:0]           DONE,
    output logic                        BUSY
);

    localparam int SW = $clog2(NUM_CH);
    localparam int AW = $clog2(NUM_LEDS);
    localparam int CW = (LATCH_CLKS > 1) ? $clog2(LATCH_CLKS) : 1;

    localparam logic [AW-1:0] LAST_PIX   = AW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CLKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_LATCH   = 3'd5;

    logic [2:0]    state_r;
    logic [SW-1:0] last_r;      // last granted channel; search starts one past it
    logic [CW-1:0] cnt_r;       // latch-gap countdown
    logic          pick_found_s;
    logic [SW-1:0] pick_idx_s;

    // Round-robin search: first requester found walking from last+1 upwards
    // (with wrap), so the previous winner has the lowest priority.
    function automatic logic [SW:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [SW-1:0]     last);
        logic [SW:0] res;
        int          c;
        res = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            c = int'(last) + i;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end else begin
                c = c;
            end
            if (!res[SW] && req[SW'(c)]) begin
                res = {1'b1, SW'(c)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration result for the current REQ vector and pointer.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        {pick_found_s, pick_idx_s} = rr_pick(REQ, last_r);
    end

    // Frame sequencer: all outputs are registered here.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= S_IDLE;
            last_r    <= SW'(NUM_CH - 1);   // makes channel 0 the first choice
            cnt_r     <= '0;
            GNT       <= '0;
            SEL       <= '0;
            RD_EN     <= 1'b0;
            ADDR      <= '0;
            PIX_DATA  <= 24'h000000;
            PIX_VALID <= 1'b0;
            DONE      <= '0;
            BUSY      <= 1'b0;
        end else begin
            DONE <= '0;
            case (state_r)
                S_IDLE: begin
                    if (pick_found_s) begin
                        GNT     <= NUM_CH'(1'b1) << pick_idx_s;
                        SEL     <= pick_idx_s;
                        ADDR    <= '0;
                        RD_EN   <= 1'b1;
                        BUSY    <= 1'b1;
                        state_r <= S_FETCH;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    // Read strobe was raised on entry; the buffer answers next cycle.
                    RD_EN   <= 1'b0;
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    PIX_DATA  <= RD_DATA;
                    PIX_VALID <= 1'b1;
                    state_r   <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (PIX_READY) begin
                        PIX_VALID <= 1'b0;
                        if (ADDR == LAST_PIX) begin
                            state_r <= S_DRAIN;
                        end else begin
                            ADDR    <= ADDR + AW'(1);
                            RD_EN   <= 1'b1;
                            state_r <= S_FETCH;
                        end
                    end else begin
                        state_r <= S_PRESENT;
                    end
                end
                S_DRAIN: begin
                    if (!SER_BUSY) begin
                        cnt_r   <= LATCH_LOAD;
                        state_r <= S_LATCH;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                S_LATCH: begin
                    // GNT stays up so the idle-low serializer keeps driving DO.
                    if (cnt_r == '0) begin
                        DONE    <= GNT;
                        GNT     <= '0;
                        last_r  <= SEL;
                        BUSY    <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                        state_r <= S_LATCH;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    GNT       <= '0;
                    RD_EN     <= 1'b0;
                    PIX_VALID <= 1'b0;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopix_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_neopix_frame_arbiter
//
// Directed bench for neopix_frame_arbiter with NUM_LEDS=4, NUM_CH=2,
// LATCH_CLKS=8. The frame buffers are modelled so that channel c, pixel a
// returns 0x000000 + 16*c + a + 1 (ch0: 1..4, ch1: 0x11..0x14).
// Timing reference: the sample where GNT first reads nonzero is t=0 (the
// grant decision cycle ends there). With PIX_READY high and SER_BUSY low a
// frame is 12 pixel cycles + 1 drain + 8 latch, so DONE is seen at t=21,
// i.e. 22 cycles after the grant decision cycle.
// -----------------------------------------------------------------------------
module tb_neopix_frame_arbiter;

    localparam int NL = 4;
    localparam int NC = 2;
    localparam int LC = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  REQ;
    logic [1:0]  GNT;
    logic [0:0]  SEL;
    logic        RD_EN;
    logic [1:0]  ADDR;
    logic [23:0] RD_DATA;
    logic [23:0] PIX_DATA;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic        SER_BUSY;
    logic [1:0]  DONE;
    logic        BUSY;

    int compared   = 0;
    int mismatched = 0;

    // observations recorded by run_frame
    int          t_done;
    int          nhs;
    int          rden_cnt;
    int          gnt_viol;
    int          wait_ticks;
    int          stall_cnt;
    int          stall_viol;
    logic [23:0] stall_data;
    logic [23:0] hs_data [0:7];
    logic [1:0]  g0;
    logic [1:0]  done_val;
    logic        busy_at_done;

    neopix_frame_arbiter #(.NUM_LEDS(NL), .NUM_CH(NC), .LATCH_CLKS(LC)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .SEL(SEL),
        .RD_EN(RD_EN), .ADDR(ADDR), .RD_DATA(RD_DATA), .PIX_DATA(PIX_DATA),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .SER_BUSY(SER_BUSY),
        .DONE(DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Frame buffer model: synchronous read, data one cycle after RD_EN.
    always @(posedge CLK) begin
        if (RD_EN) RD_DATA <= {16'h0000, 3'b000, SEL, 2'b00, ADDR} + 24'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; REQ = 2'b00; PIX_READY = 1'b1; SER_BUSY = 1'b0;
        tick(); tick();
        RESET = 1'b0;
    endtask

    // Waits for a grant, then follows the frame until DONE, applying the
    // requested PIX_READY stall, SER_BUSY extension and REQ drop.
    task automatic run_frame(input int stall_pix, input int stall_len,
                             input int busy_len, input bit drop_req);
        int busy_left;
        t_done = -1; nhs = 0; rden_cnt = 0; gnt_viol = 0; wait_ticks = 0;
        stall_cnt = 0; stall_viol = 0; stall_data = 24'h0; g0 = 2'b00;
        done_val = 2'b00; busy_at_done = 1'b1; busy_left = 0;
        while (GNT == 2'b00 && wait_ticks < 50) begin
            tick();
            wait_ticks++;
        end
        if (GNT != 2'b00) begin
            g0 = GNT;
            for (int t = 0; t <= 200; t++) begin
                if (t > 0) tick();
                if (busy_left > 0) begin
                    SER_BUSY = 1'b1;
                    busy_left--;
                end else begin
                    SER_BUSY = 1'b0;
                end
                if (stall_len > 0 && nhs == stall_pix && stall_cnt < stall_len &&
                    (PIX_VALID || stall_cnt > 0)) begin
                    if (!PIX_VALID) stall_viol++;
                    if (stall_cnt == 0) stall_data = PIX_DATA;
                    else if (PIX_DATA !== stall_data) stall_viol++;
                    if (RD_EN) stall_viol++;
                    PIX_READY = 1'b0;
                    stall_cnt++;
                end else begin
                    PIX_READY = 1'b1;
                end
                if (RD_EN) rden_cnt++;
                if (PIX_VALID && PIX_READY) begin
                    if (nhs < 8) hs_data[nhs] = PIX_DATA;
                    nhs++;
                    if (nhs == 1 && drop_req) REQ = 2'b00;
                    if (nhs == NL) busy_left = busy_len;
                end
                if (DONE != 2'b00) begin
                    t_done = t;
                    done_val = DONE;
                    busy_at_done = BUSY;
                    break;
                end
                if (GNT !== g0) gnt_viol++;
            end
        end
        SER_BUSY = 1'b0;
        PIX_READY = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ = 2'b11; PIX_READY = 1'b1; SER_BUSY = 1'b0;
        tick(); tick();
        compared++; if (GNT !== 2'b00) begin mismatched++; $display("FAIL reset_gnt: got %b want 00", GNT); end
        compared++; if (SEL !== 1'b0) begin mismatched++; $display("FAIL reset_sel: got %b want 0", SEL); end
        compared++; if (RD_EN !== 1'b0) begin mismatched++; $display("FAIL reset_rden: got %b want 0", RD_EN); end
        compared++; if (ADDR !== 2'b00) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", ADDR); end
        compared++; if (PIX_DATA !== 24'h0) begin mismatched++; $display("FAIL reset_pixdata: got %h want 0", PIX_DATA); end
        compared++; if (PIX_VALID !== 1'b0) begin mismatched++; $display("FAIL reset_pixvalid: got %b want 0", PIX_VALID); end
        compared++; if (DONE !== 2'b00) begin mismatched++; $display("FAIL reset_done: got %b want 00", DONE); end
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        RESET = 1'b0; REQ = 2'b00;
    endtask

    task automatic test_single_frame();
        do_reset();
        REQ = 2'b01;
        run_frame(0, 0, 0, 1'b0);
        REQ = 2'b00;
        compared++; if (g0 !== 2'b01) begin mismatched++; $display("FAIL single_gnt: got %b want 01", g0); end
        compared++; if (wait_ticks !== 1) begin mismatched++; $display("FAIL single_grant_delay: got %0d want 1", wait_ticks); end
        compared++; if (t_done !== 21) begin mismatched++; $display("FAIL single_latency: got %0d want 21", t_done); end
        compared++; if (nhs !== 4) begin mismatched++; $display("FAIL single_handshakes: got %0d want 4", nhs); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (hs_data[i] !== 24'(i + 1)) begin
                mismatched++;
                $display("FAIL single_pix%0d: got %h want %h", i, hs_data[i], 24'(i + 1));
            end
        end
        compared++; if (rden_cnt !== 4) begin mismatched++; $display("FAIL single_rden_count: got %0d want 4", rden_cnt); end
        compared++; if (gnt_viol !== 0) begin mismatched++; $display("FAIL single_gnt_held: got %0d changes want 0", gnt_viol); end
        compared++; if (done_val !== 2'b01) begin mismatched++; $display("FAIL single_done: got %b want 01", done_val); end
        compared++; if (busy_at_done !== 1'b0) begin mismatched++; $display("FAIL single_busy_at_done: got %b want 0", busy_at_done); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [0:2];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        do_reset();
        REQ = 2'b11;
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, 1'b0);
            compared++; if (g0 !== exp_g[f]) begin mismatched++; $display("FAIL rr_gnt%0d: got %b want %b", f, g0, exp_g[f]); end
            compared++; if (done_val !== exp_g[f]) begin mismatched++; $display("FAIL rr_done%0d: got %b want %b", f, done_val, exp_g[f]); end
            compared++; if (t_done !== 21) begin mismatched++; $display("FAIL rr_latency%0d: got %0d want 21", f, t_done); end
            compared++; if (wait_ticks !== 1) begin mismatched++; $display("FAIL rr_regrant%0d: got %0d want 1", f, wait_ticks); end
            if (f == 1) begin
                compared++; if (hs_data[0] !== 24'h000011) begin mismatched++; $display("FAIL rr_ch1_pix0: got %h want 000011", hs_data[0]); end
                compared++; if (hs_data[3] !== 24'h000014) begin mismatched++; $display("FAIL rr_ch1_pix3: got %h want 000014", hs_data[3]); end
            end
        end
        REQ = 2'b00;
    endtask

    task automatic test_ready_stall();
        do_reset();
        REQ = 2'b01;
        run_frame(1, 10, 0, 1'b0);
        REQ = 2'b00;
        compared++; if (stall_cnt !== 10) begin mismatched++; $display("FAIL stall_cycles: got %0d want 10", stall_cnt); end
        compared++; if (stall_viol !== 0) begin mismatched++; $display("FAIL stall_stable: got %0d violations want 0", stall_viol); end
        compared++; if (stall_data !== 24'h000002) begin mismatched++; $display("FAIL stall_data: got %h want 000002", stall_data); end
        compared++; if (nhs !== 4) begin mismatched++; $display("FAIL stall_handshakes: got %0d want 4", nhs); end
        compared++; if (hs_data[1] !== 24'h000002) begin mismatched++; $display("FAIL stall_pix1: got %h want 000002", hs_data[1]); end
        compared++; if (hs_data[2] !== 24'h000003) begin mismatched++; $display("FAIL stall_pix2: got %h want 000003", hs_data[2]); end
        compared++; if (rden_cnt !== 4) begin mismatched++; $display("FAIL stall_rden_count: got %0d want 4", rden_cnt); end
        compared++; if (t_done !== 31) begin mismatched++; $display("FAIL stall_latency: got %0d want 31", t_done); end
        compared++; if (done_val !== 2'b01) begin mismatched++; $display("FAIL stall_done: got %b want 01", done_val); end
    endtask

    task automatic test_drain_busy();
        do_reset();
        REQ = 2'b01;
        run_frame(0, 0, 5, 1'b0);
        REQ = 2'b00;
        compared++; if (t_done !== 26) begin mismatched++; $display("FAIL drain_latency: got %0d want 26", t_done); end
        compared++; if (gnt_viol !== 0) begin mismatched++; $display("FAIL drain_gnt_held: got %0d changes want 0", gnt_viol); end
        compared++; if (done_val !== 2'b01) begin mismatched++; $display("FAIL drain_done: got %b want 01", done_val); end
        compared++; if (nhs !== 4) begin mismatched++; $display("FAIL drain_handshakes: got %0d want 4", nhs); end
    endtask

    task automatic test_reset_mid_frame();
        int  n;
        bit  found;
        do_reset();
        REQ = 2'b10;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            tick();
            n++;
            if (RD_EN && ADDR == 2'd2) found = 1'b1;
        end
        compared++; if (!found) begin mismatched++; $display("FAIL midrst_reach_pix2: got %0d want 1", found); end
        compared++; if (GNT !== 2'b10) begin mismatched++; $display("FAIL midrst_gnt_before: got %b want 10", GNT); end
        RESET = 1'b1;
        #1;
        compared++; if (GNT !== 2'b00) begin mismatched++; $display("FAIL midrst_gnt: got %b want 00", GNT); end
        compared++; if (SEL !== 1'b0) begin mismatched++; $display("FAIL midrst_sel: got %b want 0", SEL); end
        compared++; if (RD_EN !== 1'b0) begin mismatched++; $display("FAIL midrst_rden: got %b want 0", RD_EN); end
        compared++; if (ADDR !== 2'b00) begin mismatched++; $display("FAIL midrst_addr: got %0d want 0", ADDR); end
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
        compared++; if (PIX_VALID !== 1'b0) begin mismatched++; $display("FAIL midrst_pixvalid: got %b want 0", PIX_VALID); end
        compared++; if (PIX_DATA !== 24'h0) begin mismatched++; $display("FAIL midrst_pixdata: got %h want 0", PIX_DATA); end
        tick();
        compared++; if (DONE !== 2'b00) begin mismatched++; $display("FAIL midrst_done: got %b want 00", DONE); end
        RESET = 1'b0;
        REQ = 2'b11;
        n = 0;
        while (GNT == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        compared++; if (GNT !== 2'b01) begin mismatched++; $display("FAIL midrst_first_gnt: got %b want 01", GNT); end
        REQ = 2'b00;
    endtask

    task automatic test_req_drop();
        do_reset();
        REQ = 2'b01;
        run_frame(0, 0, 0, 1'b1);
        compared++; if (nhs !== 4) begin mismatched++; $display("FAIL drop_handshakes: got %0d want 4", nhs); end
        compared++; if (hs_data[3] !== 24'h000004) begin mismatched++; $display("FAIL drop_pix3: got %h want 000004", hs_data[3]); end
        compared++; if (t_done !== 21) begin mismatched++; $display("FAIL drop_latency: got %0d want 21", t_done); end
        compared++; if (done_val !== 2'b01) begin mismatched++; $display("FAIL drop_done: got %b want 01", done_val); end
        tick();
        compared++; if (BUSY !== 1'b0) begin mismatched++; $display("FAIL drop_idle_busy: got %b want 0", BUSY); end
        compared++; if (GNT !== 2'b00) begin mismatched++; $display("FAIL drop_idle_gnt: got %b want 00", GNT); end
    endtask

    initial begin
        RESET = 1'b1; REQ = 2'b00; PIX_READY = 1'b1; SER_BUSY = 1'b0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_ready_stall();
        test_drain_busy();
        test_reset_mid_frame();
        test_req_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
